branch_predict_unit: RTL and testbench

- Parametrised successor of the execute-stage branch resolver for the RISC-V core.
- Adds a fetch-side dynamic predictor: a BHT of 2-bit saturating counters plus a tagged BTB.
- Resolves branches in execute, compares the outcome with the prediction carried down the pipe, and issues a registered redirect on mispredict.
- Squashes the wrong-path instructions for a programmable number of cycles.

---
 rtl/branch_predict_unit.sv | 237 +++++++++++++++++++++++
 tb/tb_branch_predict_unit.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_unit.sv
// Purpose : fetch-side BHT/BTB branch predictor plus execute-stage resolver with registered redirect and wrong-path squash.
// Latency : prediction is combinational (0 cycles); redirect and squash appear 1 cycle after the resolving cycle.
// Backpres: none; each resolvable instruction is accepted every cycle, but it is ignored while a flush is in progress.
//
// Ports:
//   i_clk, i_rst (async, active-low)
//   i_fetch_pc -> o_pred_taken / o_pred_target         : fetch lookup
//   i_valid, pc, imm, rs1_val, rs2_val, branch_control,
//   i_pred_taken, i_pred_target                         : execute-stage resolution inputs
//   pc_update_control / pc_update_val                   : redirect strobe and target
//   ignore_curr_inst                                    : wrong-path squash
// Optional: define BRANCH_STATS_EN to add o_branch_cnt / o_mispredict_cnt.
module branch_predict_unit #(
    parameter int XLEN         = 32,
    parameter int BHT_DEPTH    = 64,
    parameter int TAG_W        = 8,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [XLEN-1:0] i_fetch_pc,
    output logic            o_pred_taken,
    output logic [XLEN-1:0] o_pred_target,
    input  logic            i_valid,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [2:0]      branch_control,
    input  logic            i_pred_taken,
    input  logic [XLEN-1:0] i_pred_target,
`ifdef BRANCH_STATS_EN
    output logic [31:0]     o_branch_cnt,
    output logic [31:0]     o_mispredict_cnt,
`endif
    output logic            pc_update_control,
    output logic [XLEN-1:0] pc_update_val,
    output logic            ignore_curr_inst
);

    localparam int IDX_W = $clog2(BHT_DEPTH);
    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

    localparam logic [2:0] BC_NONE = 3'b000;
    localparam logic [2:0] BC_BEQ  = 3'b001;
    localparam logic [2:0] BC_BNE  = 3'b010;
    localparam logic [2:0] BC_BLT  = 3'b011;
    localparam logic [2:0] BC_BGE  = 3'b100;
    localparam logic [2:0] BC_BLTU = 3'b101;
    localparam logic [2:0] BC_BGEU = 3'b110;
    localparam logic [2:0] BC_JAL  = 3'b111;

    typedef enum logic {ST_IDLE = 1'b0, ST_FLUSH = 1'b1} state_t;

    // Prediction tables. Counters and valid bits are reset; tag/target are
    // only meaningful once valid is set, so they carry no reset.
    logic [1:0]       bht_q     [BHT_DEPTH];
    logic [1:0]       bht_d     [BHT_DEPTH];
    logic             btb_vld_q [BHT_DEPTH];
    logic             btb_vld_d [BHT_DEPTH];
    logic [TAG_W-1:0] btb_tag_q [BHT_DEPTH];
    logic [XLEN-1:0]  btb_tgt_q [BHT_DEPTH];

    state_t           state_q, state_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             pc_update_control_q, pc_update_control_d;
    logic [XLEN-1:0]  pc_update_val_q, pc_update_val_d;

    // ---------------- fetch lookup (reads pre-update state) ----------------
    logic [IDX_W-1:0] fetch_idx;
    logic [TAG_W-1:0] fetch_tag;
    logic             unused_fetch_bits;

    assign fetch_idx = i_fetch_pc[IDX_W+1:2];
    assign fetch_tag = i_fetch_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign unused_fetch_bits = ^i_fetch_pc;

    always_comb begin
        o_pred_taken  = bht_q[fetch_idx][1] & btb_vld_q[fetch_idx]
                      & (btb_tag_q[fetch_idx] == fetch_tag);
        o_pred_target = o_pred_taken ? btb_tgt_q[fetch_idx] : '0;
    end

    // ---------------- execute resolution ----------------
    logic             resolve;
    logic             taken;
    logic             mispredict;
    logic [XLEN-1:0]  actual_target;
    logic [XLEN-1:0]  fall_through;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;

    assign upd_idx       = pc[IDX_W+1:2];
    assign upd_tag       = pc[IDX_W+TAG_W+1:IDX_W+2];
    assign actual_target = pc + imm;
    assign fall_through  = pc + XLEN'(4);

    // Branches arriving while a flush is running are on the wrong path.
    assign resolve = i_valid & (branch_control != BC_NONE) & (state_q == ST_IDLE);

    always_comb begin
        taken = 1'b0;
        case (branch_control)
            BC_BEQ:  taken = (rs1_val == rs2_val);
            BC_BNE:  taken = (rs1_val != rs2_val);
            BC_BLT:  taken = ($signed(rs1_val) <  $signed(rs2_val));
            BC_BGE:  taken = ($signed(rs1_val) >= $signed(rs2_val));
            BC_BLTU: taken = (rs1_val <  rs2_val);
            BC_BGEU: taken = (rs1_val >= rs2_val);
            BC_JAL:  taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    assign mispredict = resolve & ((taken != i_pred_taken)
                      | (taken & i_pred_taken & (actual_target != i_pred_target)));

    // ---------------- table update ----------------
    always_comb begin
        bht_d     = bht_q;
        btb_vld_d = btb_vld_q;
        if (resolve) begin
            if (taken) begin
                bht_d[upd_idx]     = (bht_q[upd_idx] == 2'b11) ? 2'b11 : bht_q[upd_idx] + 2'd1;
                btb_vld_d[upd_idx] = 1'b1;
            end else begin
                bht_d[upd_idx]     = (bht_q[upd_idx] == 2'b00) ? 2'b00 : bht_q[upd_idx] - 2'd1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht_q[i]     <= 2'b01;
                btb_vld_q[i] <= 1'b0;
            end
        end else begin
            bht_q     <= bht_d;
            btb_vld_q <= btb_vld_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (resolve && taken) begin
            btb_tag_q[upd_idx] <= upd_tag;
            btb_tgt_q[upd_idx] <= actual_target;
        end
    end

    // ---------------- redirect ----------------
    always_comb begin
        pc_update_control_d = mispredict;
        pc_update_val_d     = pc_update_val_q;
        if (mispredict) begin
            pc_update_val_d = taken ? actual_target : fall_through;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            pc_update_control_q <= 1'b0;
            pc_update_val_q     <= '0;
        end else begin
            pc_update_control_q <= pc_update_control_d;
            pc_update_val_q     <= pc_update_val_d;
        end
    end

    assign pc_update_control = pc_update_control_q;
    assign pc_update_val     = pc_update_val_q;

    // ---------------- flush FSM ----------------
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q     <= ST_IDLE;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (mispredict) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = CNT_W'(FLUSH_CYCLES);
                end
            end
            ST_FLUSH: begin
                // Counter value 1 marks the final squashed cycle.
                if (flush_cnt_q == CNT_W'(1)) begin
                    state_d     = ST_IDLE;
                    flush_cnt_d = '0;
                end else begin
                    flush_cnt_d = flush_cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d     = ST_IDLE;
                flush_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        ignore_curr_inst = (state_q == ST_FLUSH);
    end

`ifdef BRANCH_STATS_EN
    logic [31:0] branch_cnt_q, branch_cnt_d;
    logic [31:0] mispredict_cnt_q, mispredict_cnt_d;

    always_comb begin
        branch_cnt_d     = branch_cnt_q + (resolve ? 32'd1 : 32'd0);
        mispredict_cnt_d = mispredict_cnt_q + (mispredict ? 32'd1 : 32'd0);
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            branch_cnt_q     <= branch_cnt_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

    assign o_branch_cnt     = branch_cnt_q;
    assign o_mispredict_cnt = mispredict_cnt_q;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
module tb_branch_predict_unit;

    localparam int XLEN  = 32;
    localparam int DEPTH = 64;
    localparam int TAG_W = 8;
    localparam int FC    = 2;
    localparam int IDX_W = 6;

    logic        clk;
    logic        rst_n;
    logic [31:0] fetch_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        valid;
    logic [31:0] pc, imm, rs1, rs2;
    logic [2:0]  bc;
    logic        in_pt;
    logic [31:0] in_ptgt;
    logic        puc;
    logic [31:0] puv;
    logic        ign;
`ifdef BRANCH_STATS_EN
    logic [31:0] br_cnt, mp_cnt;
`endif

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    branch_predict_unit #(.XLEN(XLEN), .BHT_DEPTH(DEPTH), .TAG_W(TAG_W), .FLUSH_CYCLES(FC)) dut (
        .i_clk             (clk),
        .i_rst             (rst_n),
        .i_fetch_pc        (fetch_pc),
        .o_pred_taken      (pred_taken),
        .o_pred_target     (pred_target),
        .i_valid           (valid),
        .pc                (pc),
        .imm               (imm),
        .rs1_val           (rs1),
        .rs2_val           (rs2),
        .branch_control    (bc),
        .i_pred_taken      (in_pt),
        .i_pred_target     (in_ptgt),
`ifdef BRANCH_STATS_EN
        .o_branch_cnt      (br_cnt),
        .o_mispredict_cnt  (mp_cnt),
`endif
        .pc_update_control (puc),
        .pc_update_val     (puv),
        .ignore_curr_inst  (ign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_ctr  [DEPTH];
    bit          m_bv   [DEPTH];
    logic [7:0]  m_tag  [DEPTH];
    logic [31:0] m_tgt  [DEPTH];
    int          m_left;     // squashed cycles still to come
    bit          m_redir;
    logic [31:0] m_rval;

    bit          mb_res, mb_tk, mb_mis;
    logic [31:0] mb_tgt;
    int          mb_ix;

    function automatic bit m_taken(input logic [2:0] b, input logic [31:0] a, input logic [31:0] c);
        int sa, sc;
        sa = int'(a);
        sc = int'(c);
        case (b)
            3'd1: return a == c;
            3'd2: return a != c;
            3'd3: return sa < sc;
            3'd4: return sa >= sc;
            3'd5: return a < c;
            3'd6: return a >= c;
            3'd7: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit m_pred(input logic [31:0] f);
        int ix;
        logic [7:0] tg;
        ix = int'((f >> 2) % DEPTH);
        tg = 8'((f >> (IDX_W + 2)) & 32'hFF);
        return (m_ctr[ix] >= 2) && m_bv[ix] && (m_tag[ix] == tg);
    endfunction

    function automatic logic [31:0] m_pred_tgt(input logic [31:0] f);
        int ix;
        ix = int'((f >> 2) % DEPTH);
        return m_pred(f) ? m_tgt[ix] : 32'h0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_ctr[i] = 1;
                m_bv[i]  = 1'b0;
            end
            m_left  = 0;
            m_redir = 1'b0;
            m_rval  = 32'h0;
        end else begin
            mb_res  = valid && (bc != 3'd0) && (m_left == 0);
            m_redir = 1'b0;
            if (m_left > 0) m_left = m_left - 1;
            if (mb_res) begin
                mb_tk  = m_taken(bc, rs1, rs2);
                mb_tgt = pc + imm;
                mb_ix  = int'((pc >> 2) % DEPTH);
                mb_mis = (mb_tk != in_pt) || (mb_tk && in_pt && (mb_tgt != in_ptgt));
                if (mb_tk) begin
                    m_ctr[mb_ix] = (m_ctr[mb_ix] < 3) ? m_ctr[mb_ix] + 1 : 3;
                    m_bv[mb_ix]  = 1'b1;
                    m_tag[mb_ix] = 8'((pc >> (IDX_W + 2)) & 32'hFF);
                    m_tgt[mb_ix] = mb_tgt;
                end else begin
                    m_ctr[mb_ix] = (m_ctr[mb_ix] > 0) ? m_ctr[mb_ix] - 1 : 0;
                end
                if (mb_mis) begin
                    m_redir = 1'b1;
                    m_rval  = mb_tk ? mb_tgt : pc + 32'd4;
                    m_left  = FC;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_pred_taken",  {31'b0, pred_taken}, {31'b0, m_pred(fetch_pc)});
            check("cyc_pred_target", pred_target, m_pred_tgt(fetch_pc));
            check("cyc_redirect",    {31'b0, puc}, {31'b0, m_redir});
            check("cyc_redir_val",   puv, m_rval);
            check("cyc_ignore",      {31'b0, ign}, {31'b0, m_left > 0});
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic resolve(input logic v, input logic [2:0] b, input logic [31:0] p,
                           input logic [31:0] im, input logic [31:0] a, input logic [31:0] c,
                           input logic pt, input logic [31:0] ptg);
        valid = v; bc = b; pc = p; imm = im; rs1 = a; rs2 = c; in_pt = pt; in_ptgt = ptg;
        cyc();
        valid = 1'b0; bc = 3'd0;
    endtask

    typedef struct {
        logic        v;
        logic [2:0]  b;
        logic [31:0] p, im, a, c;
    } vec_t;

    vec_t vecs[6];

    initial begin
        rst_n = 1'b0; fetch_pc = 32'h100; valid = 1'b0; pc = 0; imm = 0;
        rs1 = 0; rs2 = 0; bc = 3'd0; in_pt = 1'b0; in_ptgt = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pred_taken",  {31'b0, pred_taken}, 32'd0);
        check("rst_pred_target", pred_target, 32'h0);
        check("rst_redirect",    {31'b0, puc}, 32'd0);
        check("rst_redir_val",   puv, 32'h0);
        check("rst_ignore",      {31'b0, ign}, 32'd0);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        cyc();

        // Taken BEQ predicted not-taken; same-cycle lookup of idx 0 sees old state.
        resolve(1, 3'd1, 32'h100, 32'h20, 32'd5, 32'd5, 0, 32'h0);
        check("beq_redirect", {31'b0, puc}, 32'd1);
        check("beq_redir_val", puv, 32'h120);
        check("beq_ignore1", {31'b0, ign}, 32'd1);
        cyc();
        check("beq_redirect_n2", {31'b0, puc}, 32'd0);
        check("beq_ignore2", {31'b0, ign}, 32'd1);
        cyc();
        check("beq_ignore3", {31'b0, ign}, 32'd0);

        // Two more taken BEQs, correctly predicted.
        resolve(1, 3'd1, 32'h100, 32'h20, 32'd5, 32'd5, 1, 32'h120);
        check("beq2_no_redirect", {31'b0, puc}, 32'd0);
        resolve(1, 3'd1, 32'h100, 32'h20, 32'd5, 32'd5, 1, 32'h120);
        fetch_pc = 32'h100; #1;
        check("lookup100_taken",  {31'b0, pred_taken}, 32'd1);
        check("lookup100_target", pred_target, 32'h120);

        // Signed vs unsigned compares.
        resolve(1, 3'd3, 32'h208, 32'h40, 32'hFFFF_FFFF, 32'd1, 0, 32'h0);
        check("blt_redirect", {31'b0, puc}, 32'd1);
        check("blt_redir_val", puv, 32'h248);
        cyc(); cyc();
        resolve(1, 3'd5, 32'h30C, 32'h40, 32'hFFFF_FFFF, 32'd1, 1, 32'h34C);
        check("bltu_redirect", {31'b0, puc}, 32'd1);
        check("bltu_redir_val", puv, 32'h310);
        cyc(); cyc();

        // JAL with target wrap-around.
        resolve(1, 3'd7, 32'hFFFF_FFF8, 32'h10, 32'h0, 32'h0, 0, 32'h0);
        check("jal_redir_val", puv, 32'h8);
        cyc(); cyc();
        fetch_pc = 32'hFFFF_FFF8; #1;
        check("jal_lookup_taken",  {31'b0, pred_taken}, 32'd1);
        check("jal_lookup_target", pred_target, 32'h8);

        // Mixed vectors checked by the model only.
        vecs[0] = '{1, 3'd4, 32'h410, 32'h20, 32'hFFFF_FFFB, 32'd3};  // BGE -5>=3: not taken
        vecs[1] = '{1, 3'd6, 32'h414, 32'h20, 32'hFFFF_FFFB, 32'd3};  // BGEU: taken
        vecs[2] = '{1, 3'd2, 32'h418, 32'h20, 32'd9, 32'd9};          // BNE equal: not taken
        vecs[3] = '{1, 3'd0, 32'h41C, 32'h20, 32'd1, 32'd2};          // none
        vecs[4] = '{0, 3'd1, 32'h420, 32'h20, 32'd1, 32'd1};          // not valid
        vecs[5] = '{1, 3'd4, 32'h424, 32'h8,  32'd7, 32'hFFFF_FFFF};  // BGE 7>=-1: taken
        for (int i = 0; i < 6; i++) begin
            fetch_pc = vecs[i].p;
            resolve(vecs[i].v, vecs[i].b, vecs[i].p, vecs[i].im, vecs[i].a, vecs[i].c, 0, 32'h0);
            cyc(); cyc();
        end

        // Mispredict followed immediately by a wrong-path branch.
        resolve(1, 3'd2, 32'h404, 32'h10, 32'd1, 32'd2, 0, 32'h0);
        check("bne_redir_val", puv, 32'h414);
        resolve(1, 3'd1, 32'h500, 32'h20, 32'd7, 32'd7, 0, 32'h0);
        check("wrongpath_no_redirect", {31'b0, puc}, 32'd0);
        check("wrongpath_val_held", puv, 32'h414);
        check("wrongpath_ignore", {31'b0, ign}, 32'd1);
        cyc();
        fetch_pc = 32'h500; #1;
        check("wrongpath_no_btb", {31'b0, pred_taken}, 32'd0);
        fetch_pc = 32'h100; #1;
        check("idx0_intact_taken",  {31'b0, pred_taken}, 32'd1);
        check("idx0_intact_target", pred_target, 32'h120);

        // Reset asserted mid-flush.
        cyc();
        resolve(1, 3'd2, 32'h604, 32'h10, 32'd1, 32'd2, 0, 32'h0);
        check("flush_before_rst", {31'b0, ign}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_ignore",   {31'b0, ign}, 32'd0);
        check("rst_mid_redirect", {31'b0, puc}, 32'd0);
        check("rst_mid_val",      puv, 32'h0);
        cyc();
        rst_n = 1'b1;
        fetch_pc = 32'h100; #1;
        check("rst_bht_cleared", {31'b0, pred_taken}, 32'd0);
        cyc(); cyc();

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
